// File: rtl/user_pos_pkg.sv
// Shared types and constants for the user position controller and its collision helpers.
package user_pos_pkg;

  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALC   = 3'd1,
    QUERY  = 3'd2,
    WAIT   = 3'd3,
    COMMIT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // One step along an axis, clamped to [0, max_pos]; the 13-bit sum keeps the overflow visible.
  function automatic logic [11:0] step_sat(input logic [11:0] pos, input logic [11:0] step,
                                           input logic [11:0] max_pos, input logic inc);
    logic [12:0] sum;
    sum = {1'b0, pos} + {1'b0, step};
    if (inc) begin
      step_sat = (sum > {1'b0, max_pos}) ? max_pos : sum[11:0];
    end else begin
      step_sat = (pos < step) ? 12'd0 : (pos - step);
    end
  endfunction

endpackage

// File: rtl/user_corner_addr.sv
// Maps a rectangle origin plus corner index to the {row, col} tile address of that corner.
module user_corner_addr
  import user_pos_pkg::*;
#(
  parameter int WIDTH     = 100,
  parameter int HEIGHT    = 100,
  parameter int TILE_LOG2 = 4
) (
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  input  logic [1:0]  i_corner,
  output logic [11:0] o_addr
);

  logic [11:0] w_px;
  logic [11:0] w_py;

  // Corner bit 0 selects the right edge, bit 1 the bottom edge.
  always_comb begin
    w_px   = i_x + (i_corner[0] ? 12'(WIDTH - 1) : 12'd0);
    w_py   = i_y + (i_corner[1] ? 12'(HEIGHT - 1) : 12'd0);
    o_addr = {6'(w_py >> TILE_LOG2), 6'(w_px >> TILE_LOG2)};
  end

endmodule

// File: rtl/user_position_ctl.sv
// Moves the user rectangle one step per frame tick, rejecting moves whose corners land on wall tiles.
module user_position_ctl
  import user_pos_pkg::*;
#(
  parameter int WIDTH     = 100,
  parameter int HEIGHT    = 100,
  parameter int STEP      = 4,
  parameter int X_START   = 0,
  parameter int Y_START   = 250,
  parameter int TILE_LOG2 = 4
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        vsync_in,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        restart,
  input  logic        game_won,
  output logic [11:0] wall_addr,
  output logic        wall_req,
  input  logic        wall_hit,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic        busy,
  output logic        moved,
  output logic        blocked
);

  localparam logic [11:0] X_MAX   = 12'(H_ACTIVE - WIDTH);
  localparam logic [11:0] Y_MAX   = 12'(V_ACTIVE - HEIGHT);
  localparam logic [11:0] STEP12  = 12'(STEP);
  localparam logic [11:0] X_START12 = 12'(X_START);
  localparam logic [11:0] Y_START12 = 12'(Y_START);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_vsync_q;
  logic        w_tick;
  logic        w_key_any;
  dir_t        w_dir;
  logic [11:0] w_cand_x;
  logic [11:0] w_cand_y;
  logic        w_same;
  logic [1:0]  r_corner;
  logic        r_acc;
  logic [11:0] r_cand_x;
  logic [11:0] r_cand_y;
  logic [11:0] r_x;
  logic [11:0] r_y;
  logic [11:0] r_wall_addr;
  logic        r_wall_req;
  logic        r_busy;
  logic        r_moved;
  logic        r_blocked;
  logic        w_req_nxt;
  logic        w_busy_nxt;
  logic [11:0] w_addr_x;
  logic [11:0] w_addr_y;
  logic [1:0]  w_addr_corner;
  logic [11:0] w_addr;

  assign w_tick    = vsync_in & ~r_vsync_q;
  assign w_key_any = key_up | key_down | key_left | key_right;
  assign w_same    = (w_cand_x == r_x) && (w_cand_y == r_y);

  // Candidate position from the highest-priority held key.
  always_comb begin
    w_cand_x = r_x;
    w_cand_y = r_y;
    if (key_up) begin
      w_dir = DIR_UP;
    end else if (key_down) begin
      w_dir = DIR_DOWN;
    end else if (key_left) begin
      w_dir = DIR_LEFT;
    end else begin
      w_dir = DIR_RIGHT;
    end
    case (w_dir)
      DIR_UP:    w_cand_y = step_sat(r_y, STEP12, Y_MAX, 1'b0);
      DIR_DOWN:  w_cand_y = step_sat(r_y, STEP12, Y_MAX, 1'b1);
      DIR_LEFT:  w_cand_x = step_sat(r_x, STEP12, X_MAX, 1'b0);
      DIR_RIGHT: w_cand_x = key_right ? step_sat(r_x, STEP12, X_MAX, 1'b1) : r_x;
      default:   w_cand_x = r_x;
    endcase
  end

  // FSM state register.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; restart wins over every state.
  always_comb begin
    case (r_state)
      IDLE:    w_state_nxt = (w_tick && !game_won && w_key_any) ? CALC : IDLE;
      CALC:    w_state_nxt = w_same ? IDLE : QUERY;
      QUERY:   w_state_nxt = (r_corner == 2'd3) ? WAIT : QUERY;
      WAIT:    w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (restart) begin
      w_state_nxt = IDLE;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // FSM outputs: the address for the next QUERY cycle is prepared one cycle early so it can be registered.
  always_comb begin
    w_req_nxt  = (w_state_nxt == QUERY);
    w_busy_nxt = (w_state_nxt != IDLE);
    if (r_state == CALC) begin
      w_addr_x      = w_cand_x;
      w_addr_y      = w_cand_y;
      w_addr_corner = 2'd0;
    end else begin
      w_addr_x      = r_cand_x;
      w_addr_y      = r_cand_y;
      w_addr_corner = r_corner + 2'd1;
    end
  end

  user_corner_addr #(
    .WIDTH    (WIDTH),
    .HEIGHT   (HEIGHT),
    .TILE_LOG2(TILE_LOG2)
  ) u_corner_addr (
    .i_x     (w_addr_x),
    .i_y     (w_addr_y),
    .i_corner(w_addr_corner),
    .o_addr  (w_addr)
  );

  // Datapath: candidate latch, hit accumulation, position commit and registered outputs.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_q   <= 1'b0;
      r_corner    <= 2'd0;
      r_acc       <= 1'b0;
      r_cand_x    <= X_START12;
      r_cand_y    <= Y_START12;
      r_x         <= X_START12;
      r_y         <= Y_START12;
      r_wall_addr <= 12'd0;
      r_wall_req  <= 1'b0;
      r_busy      <= 1'b0;
      r_moved     <= 1'b0;
      r_blocked   <= 1'b0;
    end else begin
      r_vsync_q  <= vsync_in;
      r_wall_req <= w_req_nxt;
      r_busy     <= w_busy_nxt;
      r_moved    <= 1'b0;
      r_blocked  <= 1'b0;
      if (w_req_nxt) begin
        r_wall_addr <= w_addr;
      end
      if (restart) begin
        r_x      <= X_START12;
        r_y      <= Y_START12;
        r_acc    <= 1'b0;
        r_corner <= 2'd0;
      end else begin
        case (r_state)
          CALC: begin
            r_cand_x <= w_cand_x;
            r_cand_y <= w_cand_y;
            r_corner <= 2'd0;
            r_acc    <= 1'b0;
          end
          QUERY: begin
            r_corner <= r_corner + 2'd1;
            if (r_corner != 2'd0) begin
              r_acc <= r_acc | wall_hit;
            end
          end
          WAIT: r_acc <= r_acc | wall_hit;
          COMMIT: begin
            if (!r_acc) begin
              r_x     <= r_cand_x;
              r_y     <= r_cand_y;
              r_moved <= 1'b1;
            end else begin
              r_blocked <= 1'b1;
            end
          end
          default: r_corner <= r_corner;
        endcase
      end
    end
  end

  assign wall_addr = r_wall_addr;
  assign wall_req  = r_wall_req;
  assign x_pos     = r_x;
  assign y_pos     = r_y;
  assign busy      = r_busy;
  assign moved     = r_moved;
  assign blocked   = r_blocked;

endmodule

// File: tb/tb_user_position_ctl.sv
// Bench for user_position_ctl: frame-level reference model, wall ROM responder, directed and random frames.
module tb_user_position_ctl;

  localparam int XS = 0, YS = 250, XMAX = 700, YMAX = 500;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync_in = 1'b0;
  logic        key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic        restart = 1'b0;
  logic        game_won = 1'b0;
  logic [11:0] wall_addr;
  logic        wall_req;
  logic        wall_hit = 1'b0;
  logic [11:0] x_pos, y_pos;
  logic        busy, moved, blocked;

  bit rom [0:4095];

  int n_checks = 0, n_fail = 0;
  int n_moved = 0, n_blocked = 0, n_req = 0;

  // model state: ph 0 idle, 1 calc, 2..5 query, 6 wait, 7 commit
  int mx = XS, my = YS, cx = XS, cy = YS, ph = 0;
  bit mhit = 0, mmoved = 0, mblocked = 0, mvq = 0, mreq = 0;
  int maddr = 0;

  user_position_ctl dut (
    .pclk(pclk), .rst_n(rst_n), .vsync_in(vsync_in),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .restart(restart), .game_won(game_won),
    .wall_addr(wall_addr), .wall_req(wall_req), .wall_hit(wall_hit),
    .x_pos(x_pos), .y_pos(y_pos), .busy(busy), .moved(moved), .blocked(blocked)
  );

  always #5 pclk = ~pclk;

  // ROM answers one cycle after the request
  always @(posedge pclk) wall_hit <= wall_req ? rom[wall_addr] : 1'b0;

  function automatic int corner_addr(input int x, input int y, input int k);
    int px, py;
    px = x + ((k % 2) ? 99 : 0);
    py = y + ((k / 2) ? 99 : 0);
    return ((py / 16) % 64) * 64 + (px / 16) % 64;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx = XS; my = YS; ph = 0; mhit = 0; mmoved = 0; mblocked = 0; mvq = 0; mreq = 0; maddr = 0;
  endtask

  always @(negedge rst_n) model_reset();

  // reference model, advanced once per clock edge
  always @(posedge pclk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      bit tk;
      tk = vsync_in && !mvq;
      mvq = vsync_in;
      mmoved = 0;
      mblocked = 0;
      if (restart) begin
        mx = XS; my = YS; ph = 0;
      end else begin
        case (ph)
          0: if (tk && !game_won && (key_up || key_down || key_left || key_right)) ph = 1;
          1: begin
            cx = mx; cy = my;
            if (key_up) cy = (my >= 4) ? my - 4 : 0;
            else if (key_down) cy = (my + 4 > YMAX) ? YMAX : my + 4;
            else if (key_left) cx = (mx >= 4) ? mx - 4 : 0;
            else if (key_right) cx = (mx + 4 > XMAX) ? XMAX : mx + 4;
            if (cx == mx && cy == my) ph = 0;
            else begin
              ph = 2;
              mhit = 0;
              for (int k = 0; k < 4; k++) mhit |= rom[corner_addr(cx, cy, k)];
            end
          end
          7: begin
            if (!mhit) begin mx = cx; my = cy; mmoved = 1; end
            else mblocked = 1;
            ph = 0;
          end
          default: ph = ph + 1;
        endcase
      end
      mreq = (ph >= 2 && ph <= 5);
      if (mreq) maddr = corner_addr(cx, cy, ph - 2);
    end
  end

  // every-cycle comparison against the model
  always @(negedge pclk) begin
    check("x_pos", int'(x_pos), mx);
    check("y_pos", int'(y_pos), my);
    check("busy", int'(busy), int'(ph != 0));
    check("moved", int'(moved), int'(mmoved));
    check("blocked", int'(blocked), int'(mblocked));
    check("wall_req", int'(wall_req), int'(mreq));
    if (mreq) check("wall_addr", int'(wall_addr), maddr);
    if (moved) n_moved++;
    if (blocked) n_blocked++;
    if (wall_req) n_req++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge pclk);
    #2;
  endtask

  task automatic frame();
    vsync_in = 1'b1;
    cyc(2);
    vsync_in = 1'b0;
    cyc(10);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  initial begin
    int snap_m, snap_b, snap_r, vcnt;
    for (int i = 0; i < 4096; i++) rom[i] = 1'b0;

    // reset state, then idle frames with no key
    cyc(3);
    check("rst_x", int'(x_pos), 0);
    check("rst_y", int'(y_pos), 250);
    check("rst_addr", int'(wall_addr), 0);
    rst_n = 1'b1;
    frames(3);
    check("nokey_x", int'(x_pos), 0);
    check("nokey_y", int'(y_pos), 250);
    check("nokey_moved", n_moved, 0);

    // right key, exact commit latency on the first tick
    key_right = 1'b1;
    vsync_in = 1'b1;
    cyc(2);
    vsync_in = 1'b0;
    cyc(5);
    check("lat_before_x", int'(x_pos), 0);
    cyc(1);
    check("lat_after_x", int'(x_pos), 4);
    check("lat_moved", int'(moved), 1);
    cyc(4);
    frames(4);
    check("right5_x", int'(x_pos), 20);

    // saturation at the right bound
    frames(169);
    check("x696", int'(x_pos), 696);
    frame();
    check("x_sat", int'(x_pos), 700);
    snap_m = n_moved; snap_r = n_req;
    frame();
    check("sat_x_hold", int'(x_pos), 700);
    check("sat_no_query", n_req, snap_r);
    check("sat_no_pulse", n_moved, snap_m);

    // wall only on the second corner of a left move (696,250): row 15, col 49
    key_right = 1'b0; key_left = 1'b1;
    rom[15 * 64 + 49] = 1'b1;
    snap_b = n_blocked;
    frame();
    check("blk_x", int'(x_pos), 700);
    check("blk_pulse", n_blocked, snap_b + 1);
    rom[15 * 64 + 49] = 1'b0;

    // game_won freezes movement
    game_won = 1'b1;
    snap_r = n_req;
    frame();
    check("won_x", int'(x_pos), 700);
    check("won_no_query", n_req, snap_r);
    game_won = 1'b0;

    // reach (100,100) and test up+left priority
    key_left = 1'b0;
    restart = 1'b1; cyc(1); restart = 1'b0; cyc(1);
    check("restart_x", int'(x_pos), 0);
    key_right = 1'b1; frames(25); key_right = 1'b0;
    key_up = 1'b1; frames(63);
    check("y_clamp0", int'(y_pos), 0);
    key_up = 1'b0; key_down = 1'b1; frames(25); key_down = 1'b0;
    check("pos100_x", int'(x_pos), 100);
    check("pos100_y", int'(y_pos), 100);
    key_up = 1'b1; key_left = 1'b1;
    frame();
    check("upleft_y", int'(y_pos), 96);
    check("upleft_x", int'(x_pos), 100);
    key_up = 1'b0; key_left = 1'b0;

    // restart during QUERY
    key_right = 1'b1;
    snap_m = n_moved; snap_b = n_blocked;
    vsync_in = 1'b1; cyc(2); vsync_in = 1'b0; cyc(1);
    check("q_busy", int'(busy), 1);
    check("q_req", int'(wall_req), 1);
    restart = 1'b1; cyc(1); restart = 1'b0;
    check("rs_x", int'(x_pos), 0);
    check("rs_y", int'(y_pos), 250);
    check("rs_busy", int'(busy), 0);
    cyc(10);
    check("rs_no_moved", n_moved, snap_m);
    check("rs_no_blocked", n_blocked, snap_b);

    // async reset mid-move
    frames(2);
    check("pre_rst_x", int'(x_pos), 8);
    vsync_in = 1'b1; cyc(2); vsync_in = 1'b0; cyc(1);
    rst_n = 1'b0;
    #1;
    check("arst_x", int'(x_pos), 0);
    check("arst_y", int'(y_pos), 250);
    check("arst_busy", int'(busy), 0);
    check("arst_req", int'(wall_req), 0);
    check("arst_addr", int'(wall_addr), 0);
    check("arst_moved", int'(moved), 0);
    cyc(2);
    rst_n = 1'b1;
    key_right = 1'b0;
    cyc(3);

    // random frames, keys, walls, game_won and restart
    for (int i = 0; i < 4096; i++) rom[i] = ($urandom_range(0, 15) == 0);
    vcnt = 1;
    for (int c = 0; c < 4000; c++) begin
      vcnt--;
      if (vcnt == 0) begin
        vsync_in = ~vsync_in;
        vcnt = vsync_in ? $urandom_range(1, 3) : $urandom_range(1, 14);
      end
      if ($urandom_range(0, 3) == 0) begin
        key_up = $urandom_range(0, 3) == 0;
        key_down = $urandom_range(0, 2) == 0;
        key_left = $urandom_range(0, 1) == 0;
        key_right = $urandom_range(0, 1) == 0;
      end
      if ($urandom_range(0, 199) == 0) game_won = ~game_won;
      restart = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    restart = 1'b0;
    cyc(12);
    check("rand_activity", int'(n_moved > 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
